hilo_mcyc_ctrl: RTL and testbench
=================================

# hilo_mcyc_ctrl

Multi-cycle HI/LO operation sequencer beside the EX stage. It owns the multiply-accumulate instructions (MADD/MADDU/MSUB/MSUBU, 2 cycles) and the divides (DIV/DIVU, 34 cycles, restoring shift-subtract). It raises the pipeline stall request while an operation is in flight and issues exactly one HI/LO write when the result is ready. Its HI/LO write port is merged with the EX stage's single-cycle HI/LO write before the MEM stage.

## Interface
- N_REG, 32, datapath width. The sequencer requires N_REG = 32 because the iteration count is fixed at 32.
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  EX stage holds a multi-cycle op; stays high while stalled
- i_op  in  3  0 MADD, 1 MADDU, 2 MSUB, 3 MSUBU, 4 DIV, 5 DIVU; 6–7 are ignored
- i_op0, i_op1  in  N_REG  rs / rt operand values
- i_hi, i_lo  in  N_REG  latest HI/LO value, already forwarded from MEM/WB
- i_annul  in  1  flush: abandon the current op with no write
- o_streq  out  1  stall request to the pipeline controller
- o_hilo_wen  out  1  HI/LO write enable, pulses for one cycle
- o_hi, o_lo  out  N_REG  HI/LO write data; 0 whenever o_hilo_wen = 0

## Operation

**States**

- IDLE, MACC, DIV_ON, DONE.

**IDLE**

- When i_start = 1, i_annul = 0 and i_op is 0–3:
  - Latch the 64-bit product. It is signed for 0 and 2, unsigned for 1 and 3.
  - Latch {i_hi, i_lo} and the add/sub flag.
  - Go to MACC.
- When i_start = 1, i_annul = 0 and i_op is 4–5 with i_op1 ≠ 0:
  - For DIV, latch |i_op0| and |i_op1|, plus sign_q = op0[31] ^ op1[31] and sign_r = op0[31]. For DIVU, latch the raw operands and clear both sign flags.
  - Clear the 33-bit partial remainder and the 5-bit counter.
  - Go to DIV_ON.
- When i_start = 1 with i_op 4–5 and i_op1 = 0:
  - Set the result to quotient = 0, remainder = 0.
  - Go to DONE.
- When i_op is 6–7: stay in IDLE, no stall.

**MACC**

- o_hilo_wen = 1.
- {o_hi, o_lo} = {hi, lo} + prod for MADD/MADDU, or {hi, lo} − prod for MSUB/MSUBU. Arithmetic is mod 2^64.
- Next state: IDLE.

**DIV_ON**

- Each cycle:
  - rem = {rem[31:0], dividend[31]}; dividend <<= 1.
  - If rem ≥ divisor: rem −= divisor and shift 1 into the quotient; otherwise shift 0.
  - counter++.
- After the iteration with counter = 31, go to DONE.

**DONE**

- o_hilo_wen = 1.
- o_lo = the quotient, negated if sign_q.
- o_hi = the remainder, negated if sign_r.
- −2^31 / −1 gives lo = 0x80000000, hi = 0.
- Next state: IDLE.

**o_streq**

- 1 in IDLE when an accepted start is present (combinational on i_start/i_op).
- 1 in every DIV_ON cycle.
- 0 in MACC, DONE and idle cycles.
- Forced to 0 whenever i_annul = 1.

**i_start behaviour**

- i_start stays high during MACC/DONE because the same instruction is still in EX. It is ignored outside IDLE.
- A new op is accepted only in IDLE.

**i_annul**

- Any state → IDLE on the next edge.
- o_hilo_wen = 0 in that cycle, and no latching occurs.
- It overrides a simultaneous i_start.

**Reset**

- State = IDLE; all internal registers = 0.
- o_streq = 0, o_hilo_wen = 0, o_hi = o_lo = 0, immediately (asynchronous).
- Reset during DIV_ON aborts the op with no write.

## Timing
- MADD family takes 2 cycles and stalls for 1.
  - Cycle 0: start, o_streq = 1.
  - Cycle 1: MACC write.
- DIV/DIVU takes 34 cycles and stalls for 33.
  - Cycle 0: start, o_streq = 1.
  - Cycles 1–32: DIV_ON, o_streq = 1.
  - Cycle 33: DONE write.
- Divide by zero takes 2 cycles: start (stall), then a DONE write of 0/0.
- The earliest new accept is the cycle after MACC/DONE, i.e. back in IDLE.
- Outputs are combinational from registered state and the latched operands. The only input-dependent output is IDLE-cycle o_streq.
- i_hi/i_lo are sampled only in the start cycle. Forwarding is the pipeline's responsibility.

## Test plan
- **MADD:** hi = 0, lo = 0x5, op0 = 0xFFFFFFFD, op1 = 4 → cycle 0 o_streq = 1; cycle 1 o_hilo_wen = 1, o_hi = 0xFFFFFFFF, o_lo = 0xFFFFFFF9; cycle 2 all outputs 0.
- **MSUBU:** hi = 0, lo = 0x10, op0 = 0xFFFFFFFF, op1 = 2 → cycle 1 o_hi = 0xFFFFFFFE, o_lo = 0x00000012.
- **DIV signed:** op0 = 0xFFFFFFF9, op1 = 2 → o_streq high for exactly 33 cycles; cycle 33 o_lo = 0xFFFFFFFD, o_hi = 0xFFFFFFFF, single-cycle wen.
- **DIVU:** op0 = 0xFFFFFFFF, op1 = 0x10 → cycle 33 o_lo = 0x0FFFFFFF, o_hi = 0x0000000F.
- **DIV by zero:** op1 = 0 → o_streq for 1 cycle; cycle 1 o_hilo_wen = 1, o_hi = o_lo = 0.
- **Annul and reset mid-divide:**
  - Assert i_annul in the 10th DIV_ON cycle → o_streq = 0 that cycle; IDLE next; no wen ever.
  - Restart 2 cycles later → full 34-cycle run with the correct result.
  - Assert i_rst mid-DIV_ON → outputs 0 immediately.

Source files
------------

// File: rtl/hilo_mcyc_ctrl.sv
// Multi-cycle HI/LO sequencer: multiply-accumulate (2 cycles) and restoring divide (34 cycles),
// stalling the pipeline while busy and issuing a single HI/LO write per operation.
module hilo_mcyc_ctrl #(
    parameter int unsigned N_REG = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [N_REG-1:0] i_op0,
    input  logic [N_REG-1:0] i_op1,
    input  logic [N_REG-1:0] i_hi,
    input  logic [N_REG-1:0] i_lo,
    input  logic             i_annul,
    output logic             o_streq,
    output logic             o_hilo_wen,
    output logic [N_REG-1:0] o_hi,
    output logic [N_REG-1:0] o_lo
);

    localparam int unsigned W2 = 2 * N_REG;
    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MACC = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;

    logic [W2-1:0]    prod;
    logic [W2-1:0]    acc;
    logic             sub;
    logic [N_REG-1:0] dvd;
    logic [N_REG-1:0] dvs;
    logic [N_REG-1:0] quot;
    logic [N_REG:0]   rem;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic             is_macc;
    logic             is_div;
    logic             accept;
    logic             op_signed;
    logic             div_zero;
    logic [W2-1:0]    op0_x;
    logic [W2-1:0]    op1_x;
    logic [W2-1:0]    prod_nxt;
    logic [N_REG-1:0] abs0;
    logic [N_REG-1:0] abs1;
    logic [N_REG:0]   rem_sh;
    logic [N_REG:0]   rem_nxt;
    logic             ge;
    logic [W2-1:0]    macc_res;
    logic [N_REG-1:0] q_out;
    logic [N_REG-1:0] r_out;

    // Operation decode; odd opcodes are the unsigned variants
    always_comb begin
        is_macc   = (i_op[2] == 1'b0);
        is_div    = (i_op == 3'd4) || (i_op == 3'd5);
        accept    = i_start && !i_annul && (is_macc || is_div);
        op_signed = !i_op[0];
        div_zero  = (i_op1 == '0);
    end

    // Operand extension, product and divide operand magnitudes
    always_comb begin
        op0_x    = op_signed ? {{N_REG{i_op0[N_REG-1]}}, i_op0} : {{N_REG{1'b0}}, i_op0};
        op1_x    = op_signed ? {{N_REG{i_op1[N_REG-1]}}, i_op1} : {{N_REG{1'b0}}, i_op1};
        prod_nxt = op0_x * op1_x;
        abs0     = (op_signed && i_op0[N_REG-1]) ? -i_op0 : i_op0;
        abs1     = (op_signed && i_op1[N_REG-1]) ? -i_op1 : i_op1;
    end

    // One restoring shift-subtract step plus result formatting
    always_comb begin
        rem_sh   = {rem[N_REG-1:0], dvd[N_REG-1]};
        ge       = (rem_sh >= {1'b0, dvs});
        rem_nxt  = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
        macc_res = sub ? (acc - prod) : (acc + prod);
        q_out    = sign_q ? -quot : quot;
        r_out    = sign_r ? -rem[N_REG-1:0] : rem[N_REG-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_annul) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_macc)       state_nxt = S_MACC;
                        else if (div_zero) state_nxt = S_DONE;
                        else               state_nxt = S_DIV;
                    end
                end
                S_MACC:  state_nxt = S_IDLE;
                S_DIV:   if (cnt == CW'(31)) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs derive from registered state; only the idle stall request looks at inputs
    always_comb begin
        o_streq    = 1'b0;
        o_hilo_wen = 1'b0;
        o_hi       = '0;
        o_lo       = '0;
        if (!i_rst && !i_annul) begin
            case (state)
                S_IDLE: o_streq = accept;
                S_MACC: begin
                    o_hilo_wen   = 1'b1;
                    {o_hi, o_lo} = macc_res;
                end
                S_DIV:  o_streq = 1'b1;
                S_DONE: begin
                    o_hilo_wen = 1'b1;
                    o_hi       = r_out;
                    o_lo       = q_out;
                end
                default: o_streq = 1'b0;
            endcase
        end
    end

    // Operand latching and divide iteration; an annulled cycle latches nothing
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prod   <= '0;
            acc    <= '0;
            sub    <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            quot   <= '0;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
        end else if (!i_annul) begin
            case (state)
                S_IDLE: begin
                    if (accept && is_macc) begin
                        prod <= prod_nxt;
                        acc  <= {i_hi, i_lo};
                        sub  <= i_op[1];
                    end else if (accept) begin
                        rem  <= '0;
                        quot <= '0;
                        cnt  <= '0;
                        if (div_zero) begin
                            sign_q <= 1'b0;
                            sign_r <= 1'b0;
                        end else begin
                            dvd    <= abs0;
                            dvs    <= abs1;
                            sign_q <= op_signed && (i_op0[N_REG-1] ^ i_op1[N_REG-1]);
                            sign_r <= op_signed && i_op0[N_REG-1];
                        end
                    end
                end
                S_DIV: begin
                    rem  <= rem_nxt;
                    dvd  <= {dvd[N_REG-2:0], 1'b0};
                    quot <= {quot[N_REG-2:0], ge};
                    cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mcyc_ctrl.sv
// Bench for hilo_mcyc_ctrl: cycle-level latency/result model with per-cycle compare,
// directed literal scenarios and a randomized pipeline-like driver.
module tb_hilo_mcyc_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_op0 = '0;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_hi = '0;
    logic [31:0] i_lo = '0;
    logic        i_annul = 1'b0;
    logic        o_streq;
    logic        o_hilo_wen;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    int checks = 0;
    int errors = 0;

    hilo_mcyc_ctrl #(.N_REG(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op),
        .i_op0(i_op0), .i_op1(i_op1), .i_hi(i_hi), .i_lo(i_lo), .i_annul(i_annul),
        .o_streq(o_streq), .o_hilo_wen(o_hilo_wen), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got streq=%b wen=%b hi=%h lo=%h want streq=%b wen=%b hi=%h lo=%h",
                     name, $time, act[65], act[64], act[63:32], act[31:0],
                     exp[65], exp[64], exp[63:32], exp[31:0]);
        end
    endtask

    // Architectural result {hi, lo} of an operation, straight from the instruction definitions
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input logic [31:0] h,
                                                 input logic [31:0] l);
        longint    sa, sb, q, r;
        logic [63:0] p, accv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        accv = {h, l};
        if (op <= 3'd3) begin
            if (op[0]) p = {32'd0, a} * {32'd0, b};
            else       p = 64'(sa * sb);
            return op[1] ? accv - p : accv + p;
        end
        if (b == 32'd0) return 64'd0;
        if (op == 3'd4) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Latency model: cycles remaining until the write cycle (0 = idle)
    int          left = 0;
    logic [63:0] res = '0;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst)        left <= 0;
        else if (i_annul) left <= 0;
        else if (left > 0) left <= left - 1;
        else if (i_start && i_op <= 3'd5) begin
            res  <= model_result(i_op, i_op0, i_op1, i_hi, i_lo);
            left <= (i_op >= 3'd4 && i_op1 != 32'd0) ? 33 : 1;
        end
    end

    always @(negedge i_clk) begin
        logic        e_streq, e_wen;
        logic [63:0] e_val;
        e_streq = 1'b0;
        e_wen   = 1'b0;
        e_val   = '0;
        if (!i_rst) begin
            if (left == 0)     e_streq = i_start && !i_annul && (i_op <= 3'd5);
            else if (left > 1) e_streq = !i_annul;
            else if (!i_annul) begin
                e_wen = 1'b1;
                e_val = res;
            end
        end
        check("cycle", {o_streq, o_hilo_wen, o_hi, o_lo}, {e_streq, e_wen, e_val});
    end

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, hold start until the write, then check stall count and written value
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input int exp_stall, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int          stall;
        logic        got;
        logic [31:0] rh, rl;
        stall = 0;
        got   = 1'b0;
        rh    = '0;
        rl    = '0;
        @(posedge i_clk); #1;
        i_start = 1'b1; i_op = op; i_op0 = a; i_op1 = b; i_hi = h; i_lo = l;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge i_clk);
            if (o_streq) stall++;
            if (o_hilo_wen) begin
                got = 1'b1;
                rh  = o_hi;
                rl  = o_lo;
            end
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check({name, "_stall"}, 66'(stall), 66'(exp_stall));
        check({name, "_write"}, {1'b0, got, rh, rl}, {1'b0, 1'b1, exp_hi, exp_lo});
        @(negedge i_clk);
        check({name, "_after"}, {o_streq, o_hilo_wen, o_hi, o_lo}, 66'd0);
    endtask

    logic end_req;

    initial begin
        #2;
        check("reset_out", {o_streq, o_hilo_wen, o_hi, o_lo}, 66'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        check("model_madd", model_result(3'd0, 32'hFFFF_FFFD, 32'd4, 32'd0, 32'd5),
              64'hFFFF_FFFF_FFFF_FFF9);
        check("model_div", model_result(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0),
              64'h0000_0000_8000_0000);

        do_op("madd",  3'd0, 32'hFFFF_FFFD, 32'd4,   32'd0, 32'h5,  1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        do_op("msubu", 3'd3, 32'hFFFF_FFFF, 32'd2,   32'd0, 32'h10, 1, 32'hFFFF_FFFE, 32'h0000_0012);
        do_op("div",   3'd4, 32'hFFFF_FFF9, 32'd2,   32'd0, 32'd0, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu",  3'd5, 32'hFFFF_FFFF, 32'h10,  32'd0, 32'd0, 33, 32'h0000_000F, 32'h0FFF_FFFF);
        do_op("div0",  3'd4, 32'h1234_5678, 32'd0,   32'd7, 32'd9,  1, 32'd0, 32'd0);
        do_op("divmin",3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 33, 32'd0, 32'h8000_0000);

        // Annul in the 10th divide-busy cycle
        @(posedge i_clk); #1;
        i_start = 1'b1; i_op = 3'd4; i_op0 = 32'd100; i_op1 = 32'd7;
        repeat (10) @(posedge i_clk);
        #1 i_annul = 1'b1;
        @(negedge i_clk);
        check("annul_cycle", {o_streq, o_hilo_wen, o_hi, o_lo}, 66'd0);
        @(posedge i_clk); #1;
        i_annul = 1'b0; i_start = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                @(negedge i_clk);
                if (o_hilo_wen || o_streq) seen = 1'b1;
            end
            check("annul_quiet", 66'(seen), 66'd0);
        end
        do_op("restart", 3'd4, 32'd100, 32'd7, 32'd0, 32'd0, 33, 32'd2, 32'd14);

        // Asynchronous reset in the middle of a divide
        @(posedge i_clk); #1;
        i_start = 1'b1; i_op = 3'd5; i_op0 = 32'hDEAD_BEEF; i_op1 = 32'd3;
        repeat (15) @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1 check("rst_mid_div", {o_streq, o_hilo_wen, o_hi, o_lo}, 66'd0);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        do_op("after_rst", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 1,
              32'hFFFF_FFFF, 32'h0000_0002);

        // Randomized pipeline-like traffic with occasional flushes
        end_req = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge i_clk); #1;
            if (i_annul || end_req || (i_start && i_op > 3'd5)) begin
                i_start = 1'b0;
                i_annul = 1'b0;
                end_req = 1'b0;
            end else if (!i_start && $urandom_range(0, 2) == 0) begin
                i_start = 1'b1;
                i_annul = 1'b0;
                i_op    = 3'($urandom_range(0, 7));
                i_op0   = rand_val();
                i_op1   = rand_val();
                i_hi    = rand_val();
                i_lo    = rand_val();
            end else begin
                i_annul = ($urandom_range(0, 40) == 0);
            end
            @(negedge i_clk);
            if (o_hilo_wen) end_req = 1'b1;
        end

        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_annul = 1'b0;
        repeat (2) @(posedge i_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
